// File: rtl/jt89_pkg.sv
// Constants shared by every consumer of the JT89 mixer output word.
package jt89_pkg;
  localparam int JT89_SND_W   = 11;
  localparam int JT89_SND_MID = 1024;
endpackage

// File: rtl/jt89_i2s_div.sv
// I2S bit-clock divider: toggles bclk every DIV clk cycles and flags each falling edge.
module jt89_i2s_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic fall
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == DW'(DIV - 1));
  // fall is asserted in the cycle whose closing edge drives bclk from 1 to 0
  assign fall = wrap & bclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end
endmodule

// File: rtl/jt89_i2s_tx.sv
// Serialises the JT89 mixer word as signed MSB-aligned PCM on an I2S link, same word in both slots.
module jt89_i2s_tx
  import jt89_pkg::*;
#(
  parameter int DIV    = 4,
  parameter int SLOT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [JT89_SND_W-1:0] sound,
  input  logic                  mute,
  output logic                  bclk,
  output logic                  ws,
  output logic                  sdata,
  output logic                  sample_stb
);
  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] LAST    = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] R_FIRST = BW'(SLOT_W);
  localparam logic [BW-1:0] WS_LO   = BW'(SLOT_W - 1);
  localparam logic [BW-1:0] WS_HI   = BW'(FRAME_BITS - 2);

  logic                  fall;
  logic                  capture;
  logic [BW-1:0]         bit_cnt;
  logic [BW-1:0]         bit_nxt;
  logic [JT89_SND_W-1:0] pcm_s;
  logic [SLOT_W-1:0]     pcm;
  logic [SLOT_W-1:0]     left_sr;
  logic [SLOT_W-1:0]     right_sr;

  jt89_i2s_div #(.DIV(DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .bclk  (bclk),
    .fall  (fall)
  );

  assign capture    = fall && (bit_cnt == LAST);
  assign sample_stb = capture;
  assign bit_nxt    = capture ? '0 : bit_cnt + BW'(1);

  // Offset-binary mixer word to two's complement, then left-justified in the slot
  assign pcm_s = mute ? '0 : sound - JT89_SND_W'(JT89_SND_MID);
  assign pcm   = SLOT_W'(pcm_s) << (SLOT_W - JT89_SND_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= LAST;
      left_sr  <= '0;
      right_sr <= '0;
      sdata    <= 1'b0;
      ws       <= 1'b0;
    end else if (fall) begin
      bit_cnt <= bit_nxt;
      // ws flips one bit ahead of the slot it names
      ws      <= (bit_nxt >= WS_LO) && (bit_nxt <= WS_HI);
      if (capture) begin
        left_sr  <= pcm;
        right_sr <= pcm;
        sdata    <= pcm[SLOT_W-1];
      end else if (bit_nxt < R_FIRST) begin
        left_sr <= left_sr << 1;
        sdata   <= left_sr[SLOT_W-2];
      end else if (bit_nxt == R_FIRST) begin
        sdata <= right_sr[SLOT_W-1];
      end else begin
        right_sr <= right_sr << 1;
        sdata    <= right_sr[SLOT_W-2];
      end
    end
  end
endmodule

// File: tb/tb_jt89_i2s_tx.sv
// Bench for jt89_i2s_tx: two instances (default and DIV=1/SLOT_W=24) decoded like an I2S DAC.
module tb_jt89_i2s_tx;
  localparam int DIV_A = 4;
  localparam int SW_A  = 16;
  localparam int DIV_B = 1;
  localparam int SW_B  = 24;
  localparam int W     = 24;
  localparam int TMO   = 2200;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, rst_n_b, mute_a, mute_b;
  logic [10:0] sound_a, sound_b;
  logic        bclk_a, ws_a, sdata_a, stb_a;
  logic        bclk_b, ws_b, sdata_b, stb_b;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];

  int           rel[2];
  int           last_stb[2];
  bit           got_stb[2];
  bit           first_word[2];
  logic         p_bclk[2], p_ws[2], p_sdata[2], rise_ws[2];
  logic [W-1:0] shreg[2];
  int           nbits[2];
  int           words[2];

  jt89_i2s_tx #(.DIV(DIV_A), .SLOT_W(SW_A)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n_a),
    .sound      (sound_a),
    .mute       (mute_a),
    .bclk       (bclk_a),
    .ws         (ws_a),
    .sdata      (sdata_a),
    .sample_stb (stb_a)
  );

  jt89_i2s_tx #(.DIV(DIV_B), .SLOT_W(SW_B)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n_b),
    .sound      (sound_b),
    .mute       (mute_b),
    .bclk       (bclk_b),
    .ws         (ws_b),
    .sdata      (sdata_b),
    .sample_stb (stb_b)
  );

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: unsigned sample minus mid-scale, as 11-bit two's complement, left-justified
  function automatic logic [W-1:0] model(input int sw, input logic [10:0] snd, input logic mt);
    int v;
    if (mt) return '0;
    v = int'(snd) - 1024;
    if (v < 0) v += 2048;
    return W'(v) << (sw - 11);
  endfunction

  // scoreboard / monitor: one step per falling clk edge
  task automatic mon_step(input int i, input logic rn, input logic b, input logic w,
                          input logic s, input logic st, input logic [10:0] snd, input logic mt);
    int sw, dv;
    logic [W-1:0] mask, got, exp;
    sw = (i == 0) ? SW_A : SW_B;
    dv = (i == 0) ? DIV_A : DIV_B;
    if (!rn) begin
      rel[i] = 0; got_stb[i] = 0; first_word[i] = 1; nbits[i] = 0; shreg[i] = '0;
      p_bclk[i] = 0; p_ws[i] = 0; p_sdata[i] = 0; rise_ws[i] = 0;
      if (i == 0) exp_q_a.delete(); else exp_q_b.delete();
      return;
    end
    rel[i]++;
    if (st) begin
      if (!got_stb[i])
        chk(rel[i] + 1 == 2 * dv, $sformatf("first_stb_%0d", i), rel[i] + 1, 2 * dv);
      else
        chk(rel[i] - last_stb[i] == 4 * dv * sw, $sformatf("stb_period_%0d", i),
            rel[i] - last_stb[i], 4 * dv * sw);
      got_stb[i]  = 1;
      last_stb[i] = rel[i];
      exp = model(sw, snd, mt);
      if (i == 0) begin exp_q_a.push_back(exp); exp_q_a.push_back(exp); end
      else        begin exp_q_b.push_back(exp); exp_q_b.push_back(exp); end
    end
    if (!(p_bclk[i] && !b))
      chk(s == p_sdata[i] && w == p_ws[i], $sformatf("edge_align_%0d", i),
          {w, s}, {p_ws[i], p_sdata[i]});
    if (b && !p_bclk[i]) begin
      shreg[i] = {shreg[i][W-2:0], s};
      nbits[i]++;
      if (w != rise_ws[i]) begin
        mask = (W'(1) << sw) - W'(1);
        got  = shreg[i] & mask;
        if (!first_word[i])
          chk(nbits[i] == sw, $sformatf("ws_lead_%0d", i), nbits[i], sw);
        if ((i == 0) ? (exp_q_a.size() == 0) : (exp_q_b.size() == 0)) begin
          chk(1'b0, $sformatf("underflow_%0d", i), got, 0);
        end else begin
          exp = (i == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
          chk(got == exp, $sformatf("word_%0d", i), got, exp);
        end
        first_word[i] = 0;
        nbits[i] = 0;
        words[i]++;
      end
      rise_ws[i] = w;
    end
    p_bclk[i] = b; p_ws[i] = w; p_sdata[i] = s;
  endtask

  always @(negedge clk) begin
    mon_step(0, rst_n_a, bclk_a, ws_a, sdata_a, stb_a, sound_a, mute_a);
    mon_step(1, rst_n_b, bclk_b, ws_b, sdata_b, stb_b, sound_b, mute_b);
  end

  // driver tasks
  task automatic wait_capture(input int i);
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if ((i == 0) ? stb_a : stb_b) break;
      if (n >= TMO) begin
        chk(1'b0, $sformatf("capture_timeout_%0d", i), n, TMO);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_a();
    repeat (3) wait_capture(0);
    sound_a = 11'd0;    wait_capture(0);
    sound_a = 11'd2044; wait_capture(0);
    sound_a = 11'd2047; wait_capture(0);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1 sound_a = 11'($urandom_range(0, 2047));
    end
    wait_capture(0);
    mute_a = 1'b1; sound_a = 11'd0; wait_capture(0);
    mute_a = 1'b0; wait_capture(0);
    repeat (6) begin
      sound_a = 11'($urandom_range(0, 2047));
      mute_a  = ($urandom_range(0, 3) == 0);
      wait_capture(0);
    end
    mute_a = 1'b0;
    for (int n = 0; n < TMO && !ws_a; n++) @(negedge clk);
    chk(ws_a == 1'b1, "reach_right_slot", ws_a, 1);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #3 rst_n_a = 1'b0;
    #1 chk({bclk_a, ws_a, sdata_a, stb_a} == 4'b0000, "async_reset",
           {bclk_a, ws_a, sdata_a, stb_a}, 0);
    @(negedge clk);
    #1 rst_n_a = 1'b1;
    repeat (3) begin
      sound_a = 11'($urandom_range(0, 2047));
      wait_capture(0);
    end
    repeat (2) wait_capture(0);
  endtask

  task automatic run_b();
    wait_capture(1);
    sound_b = 11'd2047;
    wait_capture(1);
    repeat (4) begin
      sound_b = 11'($urandom_range(0, 2047));
      wait_capture(1);
    end
    repeat (2) wait_capture(1);
  endtask

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    mute_a  = 1'b0; mute_b  = 1'b0;
    sound_a = 11'd1024; sound_b = 11'd0;
    #1;
    chk({bclk_a, ws_a, sdata_a, stb_a} == 4'b0000, "reset_a", {bclk_a, ws_a, sdata_a, stb_a}, 0);
    chk({bclk_b, ws_b, sdata_b, stb_b} == 4'b0000, "reset_b", {bclk_b, ws_b, sdata_b, stb_b}, 0);
    repeat (3) @(negedge clk);
    #1 begin rst_n_a = 1'b1; rst_n_b = 1'b1; end
    fork
      run_a();
      run_b();
    join
    chk(words[0] >= 20, "words_a", words[0], 20);
    chk(words[1] >= 10, "words_b", words[1], 10);
    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
